// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: op codes, flag bit positions and sizing constants shared by the ALU issue arbiter.
package alu_arb_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_LSH  = 4'h6;
  localparam logic [3:0] ALU_RSH  = 4'h7;
  localparam logic [3:0] ALU_NOT  = 4'h8;
  localparam logic [3:0] ALU_XOR  = 4'hA;
  localparam logic [3:0] ALU_IDLE = 4'hF;
  localparam int FLG_SET = 0;
  localparam int FLG_EQ  = 1;
  localparam int FLG_GT  = 2;
  localparam int FLG_GE  = 3;
  localparam int RSP_DEPTH_MIN = 4;
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous response FIFO; head reads as zero while empty.
module alu_rsp_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  localparam int AW   = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop, w_full;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && r_count != '0;
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk)
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  // credit accounting upstream must make this unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));
endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: operands registered at C0, flags valid in C1 while ALU_sel is applied, result in C2.
module pipelined_alu
  import alu_arb_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_sel,
  output logic [31:0] ALU_out,
  output logic        set,
  output logic        eq,
  output logic        gt,
  output logic        ge
);
  logic [31:0] r_a, r_b, r_out, w_res;
  always_ff @(posedge clk) begin
    r_a   <= A;
    r_b   <= B;
    r_out <= w_res;
  end
  always_comb begin
    w_res = '0;
    case (ALU_sel)
      ALU_ADD:           w_res = r_a + r_b;
      ALU_SUB:           w_res = r_a - r_b;
      ALU_OR:            w_res = r_a | r_b;
      ALU_AND:           w_res = r_a & r_b;
      ALU_LSH:           w_res = r_a << r_b[4:0];
      ALU_RSH:           w_res = r_a >> r_b[4:0];
      ALU_NOT:           w_res = ~r_a;
      ALU_XOR:           w_res = r_a ^ r_b;
      4'h2, 4'h3, 4'h9:  w_res = 32'hDEAD_BEEF;
      default:           w_res = '0;
    endcase
  end
  assign ALU_out = r_out;
  assign set = |(r_a & r_b);
  assign eq  = r_a == r_b;
  assign gt  = r_a > r_b;
  assign ge  = r_a >= r_b;
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one pipelined_alu with credit-based, tagged responses.
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ID_W      = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_A,
  input  logic [N_REQ*32-1:0] req_B,
  input  logic [N_REQ*4-1:0] req_sel,
  output logic [31:0]        alu_A,
  output logic [31:0]        alu_B,
  output logic [3:0]         alu_sel,
  input  logic [31:0]        alu_out,
  input  logic               alu_set,
  input  logic               alu_eq,
  input  logic               alu_gt,
  input  logic               alu_ge,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_out,
  output logic [3:0]         rsp_flags
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [ID_W-1:0] r_ptr, r_id1, r_id2, w_gnt, w_lo, w_hi;
  logic            r_v1, r_v2, w_gnt_v, w_lo_v, w_hi_v, w_credit;
  logic [3:0]      r_sel, r_flags, w_sel, w_flags;
  logic [CW-1:0]   w_count;
  // in-flight ops already own a FIFO slot, so a grant is safe without ever stalling the ALU
  assign w_credit = !rst && (int'(w_count) + int'(r_v1) + int'(r_v2) < RSP_DEPTH);
  always_comb begin
    w_lo   = '0;
    w_hi   = '0;
    w_lo_v = 1'b0;
    w_hi_v = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid[i]) begin
        w_lo   = ID_W'(i);
        w_lo_v = 1'b1;
        if (ID_W'(i) >= r_ptr) begin
          w_hi   = ID_W'(i);
          w_hi_v = 1'b1;
        end
      end
    w_gnt_v   = w_credit && w_lo_v;
    w_gnt     = w_hi_v ? w_hi : w_lo;
    req_ready = '0;
    alu_A     = '0;
    alu_B     = '0;
    w_sel     = ALU_IDLE;
    for (int i = 0; i < N_REQ; i++)
      if (w_gnt_v && w_gnt == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        alu_A        = req_A[32*i +: 32];
        alu_B        = req_B[32*i +: 32];
        w_sel        = req_sel[4*i +: 4];
      end
  end
  always_comb begin
    w_flags          = '0;
    w_flags[FLG_SET] = alu_set;
    w_flags[FLG_EQ]  = alu_eq;
    w_flags[FLG_GT]  = alu_gt;
    w_flags[FLG_GE]  = alu_ge;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_ptr   <= '0;
      r_sel   <= ALU_IDLE;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_id1   <= '0;
      r_id2   <= '0;
      r_flags <= '0;
    end else begin
      if (w_gnt_v) r_ptr <= (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
      r_sel   <= w_sel;
      r_v1    <= w_gnt_v;
      r_id1   <= w_gnt;
      r_v2    <= r_v1;
      r_id2   <= r_id1;
      r_flags <= w_flags;
    end
  assign alu_sel = r_sel;
  alu_rsp_fifo #(.W(ID_W + 36), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_v2),
    .i_data  ({r_id2, alu_out, r_flags}),
    .i_pop   (rsp_ready),
    .o_data  ({rsp_id, rsp_out, rsp_flags}),
    .o_valid (rsp_valid),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench for the arbiter in front of a pipelined_alu.
module tb_alu_issue_arbiter;
  import alu_arb_pkg::*;
  localparam int N = 2;
  localparam int IDW = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_A, req_B;
  logic [N*4-1:0]  req_sel;
  logic [31:0]     alu_A, alu_B, alu_out, rsp_out;
  logic [3:0]      alu_sel, rsp_flags;
  logic            alu_set, alu_eq, alu_gt, alu_ge, rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [IDW+35:0] sb[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  alu_issue_arbiter #(.N_REQ(N), .ID_W(IDW), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_sel(req_sel),
    .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_set(alu_set), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_ge(alu_ge),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags)
  );
  pipelined_alu u_alu (
    .clk(clk), .A(alu_A), .B(alu_B), .ALU_sel(alu_sel), .ALU_out(alu_out),
    .set(alu_set), .eq(alu_eq), .gt(alu_gt), .ge(alu_ge)
  );

  function automatic logic [31:0] m_out(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h4: return a | b;
      4'h5: return a & b;
      4'h6: return a << b[4:0];
      4'h7: return a >> b[4:0];
      4'h8: return ~a;
      4'hA: return a ^ b;
      4'h2, 4'h3, 4'h9: return 32'hDEAD_BEEF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags(input logic [31:0] a, input logic [31:0] b);
    return {a >= b, a > b, a == b, |(a & b)};
  endfunction

  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i])
        sb.push_back({IDW'(i), m_out(req_sel[i*4 +: 4], req_A[i*32 +: 32], req_B[i*32 +: 32]),
                      m_flags(req_A[i*32 +: 32], req_B[i*32 +: 32])});
    total++;
    if ($countones(req_ready) > 1) begin
      bad++;
      $display("FAIL ready_onehot req_ready=%b required at most one bit", req_ready);
    end
    if (rsp_valid && rsp_ready) begin
      logic [IDW+35:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got id=%0d out=%h required no response", rsp_id, rsp_out);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_out, rsp_flags} !== e) begin
          bad++;
          $display("FAIL rsp_match got id=%0d out=%h flags=%b required id=%0d out=%h flags=%b",
                   rsp_id, rsp_out, rsp_flags, e[IDW+35:36], e[35:4], e[3:0]);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    req_sel[i*4 +: 4] = s;
    req_A[i*32 +: 32] = a;
    req_B[i*32 +: 32] = b;
  endtask

  task automatic drain;
    int n = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step;
      n++;
    end
    step;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_ADD, 32'h11, 32'h22);
    set_req(1, 1'b1, ALU_SUB, 32'h33, 32'h44);
    repeat (3) step;
    @(negedge clk);
    total += 8;
    if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b required 0", req_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b required 0", rsp_valid); end
    if (rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_id got=%0d required 0", rsp_id); end
    if (rsp_out !== '0) begin bad++; $display("FAIL reset_rsp_out got=%h required 0", rsp_out); end
    if (rsp_flags !== '0) begin bad++; $display("FAIL reset_rsp_flags got=%b required 0", rsp_flags); end
    if (alu_sel !== 4'hF) begin bad++; $display("FAIL reset_alu_sel got=%h required f", alu_sel); end
    if (alu_A !== '0) begin bad++; $display("FAIL reset_alu_A got=%h required 0", alu_A); end
    if (alu_B !== '0) begin bad++; $display("FAIL reset_alu_B got=%h required 0", alu_B); end
    step;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] e;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, ALU_XOR, 32'hF0, 32'hFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (req_ready !== e) begin bad++; $display("FAIL rr_grant%0d got=%b required %b", k, req_ready, e); end
      step;
    end
    req_valid = '0;
    drain;
  endtask

  task automatic test_single;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL single_accept got=%b required 01", req_ready); end
    step;
    req_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== (c == 3)) begin bad++; $display("FAIL single_latency_t%0d rsp_valid=%b required %b", c, rsp_valid, c == 3); end
      if (c == 3) begin
        total += 3;
        if (rsp_id !== '0) begin bad++; $display("FAIL single_id got=%0d required 0", rsp_id); end
        if (rsp_out !== 32'd12) begin bad++; $display("FAIL single_out got=%0d required 12", rsp_out); end
        if (rsp_flags !== 4'b0001) begin bad++; $display("FAIL single_flags got=%b required 0001", rsp_flags); end
      end
      step;
    end
    drain;
  endtask

  task automatic test_back_pressure;
    int acc = 0;
    int first = -1;
    logic [31:0] a = 32'd100;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, a, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      step;
      if (req_ready[0] === 1'b0 && acc > 0) begin end
      a = 32'd100 + 32'(acc);
      set_req(0, 1'b1, ALU_ADD, a, 32'd1);
    end
    total++;
    if (acc != D) begin bad++; $display("FAIL bp_accepts got=%0d required %0d", acc, D); end
    rsp_ready = 1'b1;
    @(negedge clk);
    step;
    rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        if (first < 0) first = k;
        acc++;
      end
      step;
      a = 32'd200 + 32'(acc);
      set_req(0, 1'b1, ALU_ADD, a, 32'd1);
    end
    total += 2;
    if (acc != 1) begin bad++; $display("FAIL bp_regrant_count got=%0d required 1", acc); end
    if (first != 0) begin bad++; $display("FAIL bp_regrant_cycle got=%0d required 0", first); end
    req_valid = '0;
    drain;
  endtask

  task automatic test_stream;
    logic [3:0] ops [8] = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_LSH, ALU_RSH, ALU_NOT, ALU_XOR};
    int acc = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k == 0) set_req(1, 1'b1, ALU_SUB, 32'd9, 32'd9);
      else set_req(1, 1'b1, ops[k % 8], $urandom, (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      @(negedge clk);
      if (req_ready[1]) acc++;
      step;
    end
    req_valid = '0;
    total++;
    if (acc != 100) begin bad++; $display("FAIL stream_accepts got=%0d required 100", acc); end
    drain;
  endtask

  task automatic test_reset_mid;
    int acc = 0;
    int n = 0;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    while (acc < 3 && n < 20) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      step;
      n++;
    end
    total++;
    if (acc != 3) begin bad++; $display("FAIL rstmid_setup accepts=%0d required 3", acc); end
    req_valid = '0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp%0d rsp_valid=%b required 0", k, rsp_valid); end
      step;
    end
    @(negedge clk);
    total += 2;
    if (rsp_out !== '0) begin bad++; $display("FAIL rstmid_rsp_out got=%h required 0", rsp_out); end
    if (alu_sel !== 4'hF) begin bad++; $display("FAIL rstmid_alu_sel got=%h required f", alu_sel); end
    step;
    set_req(0, 1'b1, ALU_XOR, 32'h1234, 32'h1);
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmid_accept got=%b required 01", req_ready); end
    step;
    req_valid = '0;
    drain;
  endtask

  task automatic test_error;
    logic [3:0] ecodes [3] = '{4'h3, 4'h2, 4'h9};
    int got = 0;
    int n = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, ecodes[k], $urandom, $urandom);
      @(negedge clk);
      total++;
      if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL err_accept%0d got=%b required 1", k, req_ready[0]); end
      step;
    end
    req_valid = '0;
    while (got < 3 && n < 20) begin
      @(negedge clk);
      if (rsp_valid) begin
        total++;
        if (rsp_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_out%0d got=%h required deadbeef", got, rsp_out); end
        got++;
      end
      step;
      n++;
    end
    total++;
    if (got != 3) begin bad++; $display("FAIL err_timeout responses=%0d required 3", got); end
    drain;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_A = '0;
    req_B = '0;
    req_sel = '0;
    rsp_ready = 1'b0;
    test_reset;
    test_round_robin;
    test_single;
    test_back_pressure;
    test_stream;
    test_reset_mid;
    test_error;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
